round_robin_distributor: RTL

- Splits one valid/ready input stream across SIZE output channels in round-robin order. It is the one-to-many counterpart of the round-robin arbiter.
- Sits where a single producer feeds a pool of equivalent consumers, for example a dispatcher to parallel processing lanes.
- Each output channel has a one-entry registered slot, so all outputs are registered and fairness is maintained by a rotating pointer.

---
 rtl/round_robin_distributor_if.sv | 49 ++++
 rtl/round_robin_distributor.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/round_robin_distributor_if.sv
// ---------------------------------------------------------------------------
// round_robin_distributor_if
//
// Handshake bundle for round_robin_distributor: one valid/ready input stream
// and SIZE valid/ready output channels with a flattened payload bus.
//
// Signals:
//   upstream_valid    producer -> distributor   input beat valid
//   upstream_ready    distributor -> producer   input beat accepted
//   upstream_data     producer -> distributor   input payload (WIDTH bits)
//   downstream_valid  distributor -> consumers  per-channel valid, bit i = channel i
//   downstream_ready  consumers -> distributor  per-channel ready, bit i = channel i
//   downstream_data   distributor -> consumers  channel i at [i*WIDTH +: WIDTH]
//
// Modports:
//   slave  - the distributor itself
//   master - the surrounding producer/consumer side
// ---------------------------------------------------------------------------
interface round_robin_distributor_if #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 8
);

    logic                   upstream_valid;
    logic                   upstream_ready;
    logic [WIDTH-1:0]       upstream_data;
    logic [SIZE-1:0]        downstream_valid;
    logic [SIZE-1:0]        downstream_ready;
    logic [SIZE*WIDTH-1:0]  downstream_data;

    modport slave (
        input  upstream_valid,
        output upstream_ready,
        input  upstream_data,
        output downstream_valid,
        input  downstream_ready,
        output downstream_data
    );

    modport master (
        output upstream_valid,
        input  upstream_ready,
        output upstream_data,
        input  downstream_valid,
        output downstream_ready,
        input  downstream_data
    );

endinterface

// File: rtl/round_robin_distributor.sv
// ---------------------------------------------------------------------------
// round_robin_distributor
//
// Splits one valid/ready input stream across SIZE output channels in
// round-robin order. Each channel owns a one-entry registered slot, so every
// downstream output comes straight from a flop. A rotating pointer names the
// channel that gets first claim on the next beat, which keeps the channels
// evenly loaded.
//
// Parameters:
//   SIZE   number of output channels (must be >= 2)
//   WIDTH  payload width in bits
//
// Ports:
//   clock    system clock, rising edge
//   resetn   asynchronous active-low reset; clears all slots and the pointer
//   bus      round_robin_distributor_if.slave handshake bundle
//   pointer  current round-robin start channel (observability)
//
// Build option:
//   ROUND_ROBIN_DISTRIBUTOR_STRICT_ORDER_EN
//     undefined: work-conserving - the first available channel at or after
//                the pointer (wrapping) takes the beat, busy channels are
//                skipped.
//     defined:   strict cyclic order - only the channel at the pointer may
//                take the beat, so one stalled channel stalls the stream.
// ---------------------------------------------------------------------------
module round_robin_distributor #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     resetn,
    round_robin_distributor_if.slave bus,
    output logic [$clog2(SIZE)-1:0]  pointer
);

    localparam int PTR_W = $clog2(SIZE);

    // Slot storage: one valid flag and one payload register per channel.
    logic [SIZE-1:0]       slot_valid;
    logic [WIDTH-1:0]      slot_data [SIZE];

    // A channel can take a beat when its slot is empty, or when it is full
    // but its consumer is draining it this very cycle.
    logic [SIZE-1:0]       available;
    logic [PTR_W-1:0]      sel;
    logic                  sel_found;
    logic [PTR_W-1:0]      ptr_next;
    logic                  transfer;
    logic [SIZE-1:0]       load;
    logic [SIZE*WIDTH-1:0] data_flat;

    assign available = ~slot_valid | bus.downstream_ready;

`ifdef ROUND_ROBIN_DISTRIBUTOR_STRICT_ORDER_EN

    // Strict order: the pointer channel is the only candidate.
    always_comb begin
        sel       = pointer;
        sel_found = available[pointer];
    end

`else

    // Channel index base+offset reduced modulo SIZE. offset < SIZE, so one
    // conditional subtraction is enough and non-power-of-two SIZE never
    // produces an out-of-range index.
    function automatic logic [PTR_W-1:0] wrap_index(input logic [PTR_W-1:0] base,
                                                    input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= SIZE) begin
            sum = sum - SIZE;
        end
        return PTR_W'(sum);
    endfunction

    // Work-conserving scan: first available channel starting at the pointer.
    // NOTE: every variable written in this block gets a default before the
    // loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic [PTR_W-1:0] idx;
        sel       = pointer;
        sel_found = 1'b0;
        idx       = '0;
        for (int k = 0; k < SIZE; k++) begin
            idx = wrap_index(pointer, k);
            if (!sel_found && available[idx]) begin
                sel_found = 1'b1;
                sel       = idx;
            end
        end
    end

`endif

    // Ready depends only on slot state and downstream_ready, never on
    // upstream_valid, so a producer may derive valid from ready safely.
    assign bus.upstream_ready = sel_found;
    assign transfer           = bus.upstream_valid & sel_found;

    // Explicit wrap keeps the pointer inside 0..SIZE-1 for any SIZE.
    assign ptr_next = (sel == PTR_W'(SIZE - 1)) ? '0 : sel + 1'b1;

    // One-hot load strobe: exactly one slot loads on a transfer.
    assign load = transfer ? (SIZE'(1) << sel) : '0;

    // NOTE: state is written with non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pointer    <= '0;
            slot_valid <= '0;
            // NOTE: the payload array is reset as well because the outputs
            // are defined to read zero out of reset; it is small (SIZE words).
            for (int i = 0; i < SIZE; i++) begin
                slot_data[i] <= '0;
            end
        end else begin
            if (transfer) begin
                pointer <= ptr_next;
            end
            for (int i = 0; i < SIZE; i++) begin
                if (load[i]) begin
                    // Load wins over drain: a same-cycle drain and refill
                    // leaves the slot full with the new beat.
                    slot_valid[i] <= 1'b1;
                    slot_data[i]  <= bus.upstream_data;
                end else if (bus.downstream_ready[i]) begin
                    // Clearing an already-empty slot is harmless, so the
                    // drain condition does not need slot_valid.
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Flatten the slot registers onto the channel payload bus.
    always_comb begin
        data_flat = '0;
        for (int i = 0; i < SIZE; i++) begin
            data_flat[i*WIDTH +: WIDTH] = slot_data[i];
        end
    end

    assign bus.downstream_valid = slot_valid;
    assign bus.downstream_data  = data_flat;

endmodule
